// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM fade controller.
package pwm_pkg;

    // Default PWM resolution in bits (period = 2^R clk cycles).
    localparam int unsigned PWM_R_DEF = 10;

    // Default width of the period-divider field.
    localparam int unsigned PWM_D_DEF = 8;

    // Fade controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fade_state_t;

endpackage

// File: rtl/pwm_period_gen.sv
// Free-running R-bit PWM period counter with a duty shadow register.
// The duty is sampled only at the period boundary, so the output never
// sees a mid-period duty change. pwm_out is registered and lags cnt by 1.
module pwm_period_gen
    import pwm_pkg::*;
#(
    parameter int unsigned R = PWM_R_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [R-1:0] duty_in,
    output logic         period_tick,
    output logic         pwm_out
);

    logic [R-1:0] cnt_q;
    logic [R-1:0] cnt_d;
    logic [R-1:0] duty_act_q;
    logic [R-1:0] duty_act_d;
    logic         pwm_q;
    logic         pwm_d;

    // Next-state for counter, duty shadow and comparator output.
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        duty_act_d = duty_act_q;
        if (period_tick) begin
            duty_act_d = duty_in;
        end
        pwm_d = (cnt_q < duty_act_q);
    end

    // Generator flops; asynchronous reset forces the output low at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    // Last count of the period marks the boundary.
    always_comb begin
        period_tick = (cnt_q == '1);
        pwm_out     = pwm_q;
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade/ramp controller: accepts a move command and walks the duty
// toward the target by a saturating step every (div+1) PWM periods.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned R = PWM_R_DEF,
    parameter int unsigned D = PWM_D_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [R-1:0] cmd_target,
    input  logic [R-1:0] cmd_step,
    input  logic [D-1:0] cmd_div,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [R-1:0] duty_cur,
    output logic         period_tick,
    output logic         pwm_out
);

    fade_state_t  state_q;
    fade_state_t  state_d;
    logic [R-1:0] duty_cur_q;
    logic [R-1:0] duty_cur_d;
    logic [R-1:0] target_q;
    logic [R-1:0] target_d;
    logic [R-1:0] step_q;
    logic [R-1:0] step_d;
    logic [D-1:0] div_q;
    logic [D-1:0] div_d;
    logic [D-1:0] div_cnt_q;
    logic [D-1:0] div_cnt_d;
    logic [R-1:0] duty_next;

    // One saturating step toward the target, computed in R+1 bits so the
    // ramp can neither overshoot nor wrap below zero.
    function automatic logic [R-1:0] step_toward(
        input logic [R-1:0] cur,
        input logic [R-1:0] tgt,
        input logic [R-1:0] stp
    );
        logic [R:0] sum;
        logic [R:0] diff;
        sum  = {1'b0, cur} + {1'b0, stp};
        diff = {1'b0, cur} - {1'b0, stp};
        if (tgt > cur) begin
            return (sum > {1'b0, tgt}) ? tgt : sum[R-1:0];
        end
        return (diff[R] || (diff[R-1:0] < tgt)) ? tgt : diff[R-1:0];
    endfunction

    pwm_period_gen #(
        .R(R)
    ) u_gen (
        .clk        (clk),
        .reset      (reset),
        .duty_in    (duty_cur_q),
        .period_tick(period_tick),
        .pwm_out    (pwm_out)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command and ramp datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_cur_q <= '0;
            target_q   <= '0;
            step_q     <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
        end else begin
            duty_cur_q <= duty_cur_d;
            target_q   <= target_d;
            step_q     <= step_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

    // Next state plus datapath updates; abort wins over a coincident step.
    always_comb begin
        state_d    = state_q;
        duty_cur_d = duty_cur_q;
        target_d   = target_q;
        step_d     = step_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        duty_next  = step_toward(duty_cur_q, target_q, step_q);
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    target_d  = cmd_target;
                    step_d    = cmd_step;
                    div_d     = cmd_div;
                    div_cnt_d = cmd_div;
                    if (cmd_step == '0) begin
                        duty_cur_d = cmd_target;
                        state_d    = DONE;
                    end else if (cmd_target == duty_cur_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (period_tick) begin
                    if (div_cnt_q != '0) begin
                        div_cnt_d = div_cnt_q - 1'b1;
                    end else begin
                        duty_cur_d = duty_next;
                        div_cnt_d  = div_q;
                        if (duty_next == target_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q == WAIT) || (state_q == DONE);
        done      = (state_q == DONE);
        duty_cur  = duty_cur_q;
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl with R=4, D=4.
module tb_pwm_fade_ctrl;

    localparam int R = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [R-1:0] cmd_target;
    logic [R-1:0] cmd_step;
    logic [D-1:0] cmd_div;
    logic         abort;
    logic         busy;
    logic         done;
    logic [R-1:0] duty_cur;
    logic         period_tick;
    logic         pwm_out;

    int checks = 0;
    int errors = 0;

    pwm_fade_ctrl #(
        .R(R),
        .D(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .duty_cur   (duty_cur),
        .period_tick(period_tick),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the negedge of the next cycle with period_tick high.
    task automatic wait_tick(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_tick) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_tick_seen"}, found, 1);
    endtask

    // Present a command in a tick cycle so it is accepted on the tick edge.
    task automatic send_cmd(input string tag, input logic [R-1:0] t,
                            input logic [R-1:0] s, input logic [D-1:0] d);
        wait_tick(tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        cmd_target = t;
        cmd_step   = s;
        cmd_div    = d;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Count pwm_out highs over one full period once duty_act holds the
    // value programmed before the next boundary.
    task automatic count_high(input string tag, input int exp);
        int n;
        n = 0;
        wait_tick(tag);
        @(posedge clk);
        @(posedge clk);
        repeat (16) begin
            @(negedge clk);
            if (pwm_out) n++;
        end
        chk({tag, "_high_cycles"}, n, exp);
    endtask

    initial begin
        int ntick;
        int first_tick;
        int last_tick;
        int pwm_high;
        int exp3[8];

        // 1: reset state and idle behaviour
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_step   = '0;
        cmd_div    = '0;
        abort      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_duty", duty_cur, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", period_tick, 0);
        reset = 1'b0;
        ntick = 0; first_tick = -1; last_tick = -1; pwm_high = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (period_tick) begin
                ntick++;
                if (first_tick < 0) first_tick = k;
                last_tick = k;
            end
            if (pwm_out) pwm_high++;
        end
        chk("idle_tick_count", ntick, 2);
        chk("idle_first_tick", first_tick, 15);
        chk("idle_last_tick", last_tick, 31);
        chk("idle_pwm_high", pwm_high, 0);
        chk("idle_duty", duty_cur, 0);
        chk("idle_ready", cmd_ready, 1);

        // 2: ramp up 0 -> 10, step 4, div 0
        send_cmd("up", 4'd10, 4'd4, 4'd0);
        chk("up_busy", busy, 1);
        chk("up_duty_hold", duty_cur, 0);
        wait_tick("up1"); @(negedge clk);
        chk("up_duty1", duty_cur, 4);
        chk("up_done1", done, 0);
        wait_tick("up2"); @(negedge clk);
        chk("up_duty2", duty_cur, 8);
        chk("up_done2", done, 0);
        wait_tick("up3"); @(negedge clk);
        chk("up_duty3", duty_cur, 10);
        chk("up_done3", done, 1);
        chk("up_ready_in_done", cmd_ready, 0);
        @(negedge clk);
        chk("up_done_end", done, 0);
        chk("up_ready_end", cmd_ready, 1);
        chk("up_busy_end", busy, 0);
        count_high("up_pwm", 10);

        // 3: ramp down 10 -> 0, step 3, div 1 (no underflow)
        exp3 = '{10, 7, 7, 4, 4, 1, 1, 0};
        send_cmd("dn", 4'd0, 4'd3, 4'd1);
        for (int i = 0; i < 8; i++) begin
            wait_tick("dn"); @(negedge clk);
            chk($sformatf("dn_duty%0d", i), duty_cur, exp3[i]);
            chk($sformatf("dn_done%0d", i), done, (i == 7) ? 1 : 0);
        end
        @(negedge clk);
        chk("dn_done_end", done, 0);
        chk("dn_duty_end", duty_cur, 0);

        // 4: immediate jump to 15, then a command held through DONE
        send_cmd("jmp", 4'd15, 4'd0, 4'd0);
        chk("jmp_duty", duty_cur, 15);
        chk("jmp_done", done, 1);
        @(negedge clk);
        chk("jmp_done_end", done, 0);
        count_high("jmp_pwm", 15);
        cmd_target = 4'd5; cmd_step = '0; cmd_div = '0; cmd_valid = 1'b1;
        @(negedge clk);
        chk("hold_duty5", duty_cur, 5);
        chk("hold_done", done, 1);
        chk("hold_ready_done", cmd_ready, 0);
        cmd_target = 4'd9;
        @(negedge clk);
        chk("hold_not_taken", duty_cur, 5);
        chk("hold_ready_idle", cmd_ready, 1);
        @(negedge clk);
        chk("hold_duty9", duty_cur, 9);
        chk("hold_done2", done, 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("hold_done2_end", done, 0);
        send_cmd("zero", 4'd0, 4'd0, 4'd0);
        chk("zero_duty", duty_cur, 0);
        @(negedge clk);

        // 5: abort coincident with the third tick of 0 -> 12 step 2
        send_cmd("ab", 4'd12, 4'd2, 4'd0);
        wait_tick("ab1"); @(negedge clk);
        chk("ab_duty1", duty_cur, 2);
        wait_tick("ab2"); @(negedge clk);
        chk("ab_duty2", duty_cur, 4);
        wait_tick("ab3");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_duty_hold", duty_cur, 4);
        chk("ab_done", done, 0);
        chk("ab_ready", cmd_ready, 1);
        chk("ab_busy", busy, 0);
        @(negedge clk);
        chk("ab_done_next", done, 0);
        wait_tick("ab4"); @(negedge clk);
        chk("ab_duty_after", duty_cur, 4);

        // 6: asynchronous reset mid-ramp, then ramp again from 0
        send_cmd("rr", 4'd15, 4'd2, 4'd0);
        wait_tick("rr1"); @(negedge clk);
        chk("rr_duty1", duty_cur, 6);
        wait_tick("rr2"); @(negedge clk);
        chk("rr_duty2", duty_cur, 8);
        @(negedge clk);
        chk("rr_pwm_pre", pwm_out, 1);
        chk("rr_busy_pre", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rr_pwm_async", pwm_out, 0);
        chk("rr_duty_async", duty_cur, 0);
        chk("rr_busy_async", busy, 0);
        chk("rr_ready_async", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        send_cmd("post", 4'd3, 4'd2, 4'd0);
        wait_tick("post1"); @(negedge clk);
        chk("post_duty1", duty_cur, 2);
        chk("post_done1", done, 0);
        wait_tick("post2"); @(negedge clk);
        chk("post_duty2", duty_cur, 3);
        chk("post_done2", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
